// File: rtl/param_stream_sink.sv
// rtl/param_stream_sink.sv - parameter-stream sink: loads one tensor into RAM, 2-cycle ROM-style readback
module param_stream_sink #(
    parameter int PRECISION_0       = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 1,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int BEAT_ELEMS        = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    parameter int DEPTH             = (TENSOR_SIZE_DIM_0 * TENSOR_SIZE_DIM_1) / BEAT_ELEMS,
    parameter int ADDR_WIDTH        = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRECISION_0-1:0] data_in [BEAT_ELEMS],
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic                   reload,
    output logic                   load_done,
    output logic [ADDR_WIDTH-1:0]  beats_loaded,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   rd_ce,
    output logic [PRECISION_0-1:0] rd_data [BEAT_ELEMS]
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   count_next;
    logic                    accept;

    logic [PRECISION_0-1:0]  mem   [DEPTH][BEAT_ELEMS];
    logic [PRECISION_0-1:0]  rd_s1 [BEAT_ELEMS];
    logic [PRECISION_0-1:0]  rd_s2 [BEAT_ELEMS];

    assign data_in_ready = (state == LOAD) && !reload;
    assign accept        = data_in_valid && data_in_ready;
    assign load_done     = (state == DONE);

    always_comb begin
        state_next = state;
        count_next = beats_loaded;
        if (reload) begin
            state_next = LOAD;
            count_next = '0;
        end else if (accept) begin
            count_next = beats_loaded + 1'b1;
            if (beats_loaded == LAST_BEAT) begin
                state_next = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            beats_loaded <= '0;
        end else begin
            state        <= state_next;
            beats_loaded <= count_next;
        end
    end

    // RAM is deliberately left uninitialised; only the control state is reset.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int j = 0; j < BEAT_ELEMS; j++) begin
                mem[beats_loaded[IDX_W-1:0]][j] <= data_in[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < BEAT_ELEMS; j++) begin
                rd_s1[j] <= '0;
                rd_s2[j] <= '0;
            end
        end else if (rd_ce) begin
            for (int j = 0; j < BEAT_ELEMS; j++) begin
                rd_s1[j] <= (rd_addr < DEPTH_A) ? mem[rd_addr[IDX_W-1:0]][j] : '0;
                rd_s2[j] <= rd_s1[j];
            end
        end
    end

    assign rd_data = rd_s2;

endmodule

// File: tb/tb_param_stream_sink.sv
// tb/tb_param_stream_sink.sv - randomized self-checking bench for param_stream_sink (DEPTH=32 and 4-lane DEPTH=8)
module tb_param_stream_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] d_in [1];
    logic        valid, ready, reload, done, rd_ce;
    logic [5:0]  cnt, rd_addr;
    logic [15:0] rd_data [1];

    logic [15:0] q_in [4];
    logic        q_valid, q_ready, q_reload, q_done, q_rd_ce;
    logic [3:0]  q_cnt, q_rd_addr;
    logic [15:0] q_rd_data [4];

    param_stream_sink dut (
        .clk(clk), .rst(rst), .data_in(d_in), .data_in_valid(valid), .data_in_ready(ready),
        .reload(reload), .load_done(done), .beats_loaded(cnt), .rd_addr(rd_addr),
        .rd_ce(rd_ce), .rd_data(rd_data)
    );

    param_stream_sink #(.PARALLELISM_DIM_0(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(q_in), .data_in_valid(q_valid), .data_in_ready(q_ready),
        .reload(q_reload), .load_done(q_done), .beats_loaded(q_cnt), .rd_addr(q_rd_addr),
        .rd_ce(q_rd_ce), .rd_data(q_rd_data)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: what the tensor RAM should hold, in accept order.
    logic [15:0] ref_mem [32];
    int          ref_cnt;
    bit          ref_done;
    logic [15:0] ref_q [8][4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0; reload = 1'b0; rd_ce = 1'b0; rd_addr = '0; d_in[0] = '0;
        q_valid = 1'b0; q_reload = 1'b0; q_rd_ce = 1'b0; q_rd_addr = '0;
        for (int j = 0; j < 4; j++) q_in[j] = '0;
        tick; tick;
        rst = 1'b0;
        #1;
        ref_cnt = 0; ref_done = 0;
        checks++; if (cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready); end
        checks++; if (rd_data[0] !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h want=0", rd_data[0]); end
        checks++; if (q_cnt !== 4'd0 || q_done !== 1'b0) begin errors++; $display("FAIL reset_dut4 cnt=%0d done=%b want=0/0", q_cnt, q_done); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (q_rd_data[j] !== 16'h0) begin errors++; $display("FAIL reset_q_rd_data lane%0d got=%h want=0", j, q_rd_data[j]); end
        end
    endtask

    // Streams beats base+index until `target` beats are accepted, checking handshake every cycle.
    task automatic load_stream(input logic [15:0] base, input bit rand_valid, input int target);
        int cycles = 0;
        while (ref_cnt < target && cycles < 2000) begin
            valid   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            d_in[0] = base + 16'(ref_cnt);
            #1;
            checks++; if (ready !== !ref_done) begin errors++; $display("FAIL stream_ready got=%b want=%b", ready, !ref_done); end
            checks++; if (cnt !== 6'(ref_cnt)) begin errors++; $display("FAIL stream_cnt got=%0d want=%0d", cnt, ref_cnt); end
            checks++; if (done !== ref_done) begin errors++; $display("FAIL stream_done got=%b want=%b", done, ref_done); end
            if (valid && !ref_done) begin
                ref_mem[ref_cnt] = d_in[0];
                ref_cnt++;
                if (ref_cnt == 32) ref_done = 1;
            end
            tick;
            cycles++;
        end
        valid = 1'b0;
        checks++; if (ref_cnt < target) begin errors++; $display("FAIL stream_timeout accepted=%0d want=%0d", ref_cnt, target); end
    endtask

    task automatic check_loaded;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL loaded_done got=%b want=1", done); end
        checks++; if (cnt !== 6'd32) begin errors++; $display("FAIL loaded_cnt got=%0d want=32", cnt); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loaded_ready got=%b want=0", ready); end
    endtask

    // Back-to-back reads of every address plus out-of-range ones; data must appear two edges later.
    task automatic test_readback;
        logic [15:0] exp_q[$];
        int a;
        for (int k = 0; k < 37; k++) begin
            if (k < 36) begin
                a = (k < 32) ? k : 40 + (k - 32);
                rd_addr = 6'(a);
                exp_q.push_back((a < 32) ? ref_mem[a] : 16'h0);
            end else begin
                rd_addr = 6'd0;
            end
            rd_ce = 1'b1;
            tick;
            if (k >= 1) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                checks++; if (rd_data[0] !== e) begin errors++; $display("FAIL readback idx%0d got=%h want=%h", k - 1, rd_data[0], e); end
            end
        end
        rd_ce = 1'b0;
    endtask

    task automatic test_done_ignores;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; d_in[0] = 16'hDEAD;
            #1;
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL done_ready got=%b want=0", ready); end
            tick;
            checks++; if (cnt !== 6'd32 || done !== 1'b1) begin errors++; $display("FAIL done_hold cnt=%0d done=%b want=32/1", cnt, done); end
        end
        valid = 1'b0;
        test_readback;
    endtask

    task automatic test_reset_midload;
        reload = 1'b1; tick; reload = 1'b0;
        ref_cnt = 0; ref_done = 0;
        load_stream(16'h0AA0, 1'b1, 10);
        rst = 1'b1; valid = 1'b1; d_in[0] = 16'hBEEF;
        tick;
        rst = 1'b0; valid = 1'b0;
        ref_cnt = 0; ref_done = 0;
        #1;
        checks++; if (cnt !== 6'd0 || done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL midload_rst cnt=%0d done=%b ready=%b want=0/0/1", cnt, done, ready); end
        load_stream(16'h0200, 1'b1, 32);
        check_loaded;
        test_readback;
    endtask

    task automatic test_reload_same_cycle;
        reload = 1'b1; valid = 1'b1; d_in[0] = 16'h0300;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reload_ready got=%b want=0", ready); end
        tick;
        reload = 1'b0; valid = 1'b0;
        ref_cnt = 0; ref_done = 0;
        #1;
        checks++; if (cnt !== 6'd0 || done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL reload_state cnt=%0d done=%b ready=%b want=0/0/1", cnt, done, ready); end
        load_stream(16'h0301, 1'b0, 1);
        checks++; if (cnt !== 6'd1) begin errors++; $display("FAIL reload_cnt got=%0d want=1", cnt); end
        test_readback;
    endtask

    task automatic test_parallel;
        int n = 0;
        int cycles = 0;
        while (n < 8 && cycles < 500) begin
            q_valid = 1'($urandom_range(0, 1));
            for (int j = 0; j < 4; j++) q_in[j] = 16'(16 * n + j);
            #1;
            checks++; if (q_ready !== 1'b1 || q_done !== 1'b0 || q_cnt !== 4'(n)) begin errors++; $display("FAIL par_stream ready=%b done=%b cnt=%0d want=1/0/%0d", q_ready, q_done, q_cnt, n); end
            if (q_valid) begin
                for (int j = 0; j < 4; j++) ref_q[n][j] = q_in[j];
                n++;
            end
            tick;
            cycles++;
        end
        q_valid = 1'b0;
        checks++; if (q_done !== 1'b1 || q_cnt !== 4'd8 || q_ready !== 1'b0) begin errors++; $display("FAIL par_done done=%b cnt=%0d ready=%b want=1/8/0", q_done, q_cnt, q_ready); end
        for (int a = 0; a < 8; a++) begin
            q_rd_addr = 4'(a); q_rd_ce = 1'b1;
            tick; tick;
            for (int j = 0; j < 4; j++) begin
                checks++; if (q_rd_data[j] !== ref_q[a][j]) begin errors++; $display("FAIL par_read addr%0d lane%0d got=%h want=%h", a, j, q_rd_data[j], ref_q[a][j]); end
            end
        end
        q_rd_addr = 4'd2; tick; tick;
        q_rd_ce = 1'b0; q_rd_addr = 4'd5;
        tick; tick; tick;
        for (int j = 0; j < 4; j++) begin
            checks++; if (q_rd_data[j] !== 16'(32 + j)) begin errors++; $display("FAIL par_freeze lane%0d got=%h want=%h", j, q_rd_data[j], 16'(32 + j)); end
        end
        q_rd_ce = 1'b1; q_rd_addr = 4'd9;
        tick; tick;
        for (int j = 0; j < 4; j++) begin
            checks++; if (q_rd_data[j] !== 16'h0) begin errors++; $display("FAIL par_oob lane%0d got=%h want=0", j, q_rd_data[j]); end
        end
        q_rd_ce = 1'b0;
    endtask

    initial begin
        test_reset;
        load_stream(16'h0100, 1'b0, 32);
        check_loaded;
        test_readback;
        reload = 1'b1; tick; reload = 1'b0;
        ref_cnt = 0; ref_done = 0;
        load_stream(16'h0100, 1'b1, 32);
        check_loaded;
        test_readback;
        test_done_ignores;
        test_reset_midload;
        test_reload_same_cycle;
        test_parallel;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_stream_sink.md
Name: param_stream_sink

Overview:
- Receiving end of the parameter-stream valid/ready interface that the weight/bias sources drive.
- Accepts one full tensor as a sequence of parallel beats and stores it in an internal RAM, one entry per beat.
- Signals completion when the last beat is stored.
- Exposes a ROM-style read port (address, chip-enable, 2-cycle latency) so downstream logic or a testbench can read the loaded tensor back.

Parameters:
- PRECISION_0, 16: bit width of one element.
- TENSOR_SIZE_DIM_0, 32: tensor size, dim 0.
- TENSOR_SIZE_DIM_1, 1: tensor size, dim 1.
- PARALLELISM_DIM_0, 1: elements per beat, dim 0.
- PARALLELISM_DIM_1, 1: elements per beat, dim 1.
- BEAT_ELEMS, PARALLELISM_DIM_0*PARALLELISM_DIM_1: elements per beat (derived).
- DEPTH, (TENSOR_SIZE_DIM_0*TENSOR_SIZE_DIM_1)/BEAT_ELEMS: beats per tensor, equal to RAM entries (derived, must be ≥2).
- ADDR_WIDTH, $clog2(DEPTH)+1: width of the read address and beat counter (derived).

Ports:
- clk, input, 1: single clock, all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, PRECISION_0 x BEAT_ELEMS (unpacked array): incoming beat; element j is lane j.
- data_in_valid, input, 1: upstream beat valid.
- data_in_ready, output, 1: sink can accept a beat this cycle.
- reload, input, 1: single-cycle pulse that re-arms the sink for a new tensor.
- load_done, output, 1: full tensor is stored.
- beats_loaded, output, ADDR_WIDTH: number of beats stored since the last reset or reload.
- rd_addr, input, ADDR_WIDTH: read beat index.
- rd_ce, input, 1: read pipeline enable.
- rd_data, output, PRECISION_0 x BEAT_ELEMS (unpacked array): read beat, same lane order as data_in.

Behaviour:
- States: LOAD and DONE. Reset enters LOAD.
- Reset values: beats_loaded=0, load_done=0, both read pipeline stages=0, rd_data=0. RAM contents are not cleared.
- data_in_ready is combinational: (state==LOAD) && !reload.
- Accept condition: data_in_valid && data_in_ready.
  - On accept, RAM[beats_loaded] <= all lanes of data_in, and beats_loaded increments.
- LOAD->DONE: on the accept of beat DEPTH-1.
  - load_done=1 from the next cycle.
  - beats_loaded=DEPTH.
  - data_in_ready=0.
- In DONE, valid beats are ignored (ready low). No overwrite occurs.
- reload in any state:
  - Next state is LOAD, beats_loaded=0, load_done=0.
  - A beat presented in the same cycle is not accepted, because ready is low.
- rst has priority over reload and over accept. Reset in mid-load discards progress (beats_loaded=0, state LOAD).
- Backpressure: upstream may drop valid at any time. Gaps do not affect beat order; beat index equals accept order.
- Read port, 2-cycle latency, both stages gated by rd_ce:
  - Stage 1 <= RAM[rd_addr]; stage 2 <= stage 1; rd_data = stage 2.
  - With rd_ce low, both stages hold their values.
- rd_addr ≥ DEPTH loads zeros into stage 1.
- Read-during-write to the same address in the same cycle returns the old RAM contents.
- Reads are legal in any state and return current RAM contents.
- No arithmetic on data. Lane j of a beat maps one-to-one to lane j of the stored entry.

Test Plan:
- Defaults (DEPTH=32). After rst, stream values 0x0100+i for i=0..31 with valid held high -> ready high for 32 cycles. load_done=1 on the cycle after the last accept, beats_loaded=32, ready=0.
- Same stream with valid toggled in a random pattern -> identical RAM contents. Reading addr k with rd_ce=1 gives rd_data[0]=0x0100+k exactly 2 cycles later. Reading addr 40 gives 0.
- In DONE, keep presenting valid beats 0xDEAD -> ready stays 0. RAM is unchanged; readback of addr 5 returns 0x0105.
- Load 10 beats, assert rst, then load a full new stream 0x0200+i -> beats_loaded counts from 0. Readback of addr 3 returns 0x0203 and load_done asserts only after 32 beats.
- In DONE, pulse reload with valid high and beat 0x0300 in the same cycle -> that beat is not accepted. The next accepted beat 0x0301 is written to addr 0.
- PARALLELISM_DIM_0=4 (DEPTH=8): stream beats with lane j=0x10*i+j -> load_done after 8 accepts. Readback of addr 2 gives lanes {0x20,0x21,0x22,0x23}. Holding rd_ce low freezes rd_data.
